// File: rtl/pill_dispense_seq.sv
// Pill dispense sequencer: accepts one slot command, ramps the servo position
// out to the slot angle at a limited slew rate, dwells, ramps back home and
// pulses done. An abort in the outbound/dwell phases forces an early return.
module pill_dispense_seq #(
  parameter int unsigned STEP_CYCLES = 200000,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter logic [7:0]  HOME_POS    = 8'd0,
  parameter logic [7:0]  SLOT_PITCH  = 8'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_slot,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [7:0] pos,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_OUT  = 2'd1,
    HOLD      = 2'd2,
    MOVE_BACK = 2'd3
  } state_t;

  localparam logic [19:0] STEP_LAST = 20'(STEP_CYCLES - 1);
  localparam logic [24:0] HOLD_LAST = 25'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  target_q, target_d;
  logic [19:0] step_cnt_q, step_cnt_d;
  logic [24:0] hold_cnt_q, hold_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        abort_seen_q, abort_seen_d;

  logic [11:0] target_sum;
  logic [7:0]  target_sat;
  logic [7:0]  goal;
  logic [7:0]  pos_step;
  logic        return_req;

  // Slot angle from the command, computed wide and clamped to the servo range.
  always_comb begin
    target_sum = {4'd0, HOME_POS} + 12'(cmd_slot) * 12'(SLOT_PITCH);
    target_sat = (target_sum > 12'd255) ? 8'hFF : target_sum[7:0];
  end

  // Next position one LSB toward the current goal; saturates at the goal.
  always_comb begin
    goal = (state_q == MOVE_BACK) ? HOME_POS : target_q;
    if (pos_q < goal) begin
      pos_step = pos_q + 8'd1;
    end else if (pos_q > goal) begin
      pos_step = pos_q - 8'd1;
    end else begin
      pos_step = pos_q;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;

  // Next-state logic: sequencing, slew timing, dwell timing and abort handling.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    target_d     = target_q;
    step_cnt_d   = step_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_seen_d = abort_seen_q;
    return_req   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          target_d     = target_sat;
          step_cnt_d   = 20'd0;
          hold_cnt_d   = 25'd0;
          abort_seen_d = 1'b0;
          state_d      = (target_sat == pos_q) ? HOLD : MOVE_OUT;
        end
      end

      MOVE_OUT: begin
        // Abort wins over a step that would land on the same edge.
        if (abort) begin
          abort_seen_d = 1'b1;
          return_req   = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + 20'd1;
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = 20'd0;
            pos_d      = pos_step;
            if (pos_step == target_q) begin
              state_d    = HOLD;
              hold_cnt_d = 25'd0;
            end
          end
        end
      end

      HOLD: begin
        if (abort) begin
          abort_seen_d = 1'b1;
          return_req   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 25'd1;
          if (hold_cnt_q == HOLD_LAST) begin
            return_req = 1'b1;
          end
        end
      end

      MOVE_BACK: begin
        step_cnt_d = step_cnt_q + 20'd1;
        if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = 20'd0;
          pos_d      = pos_step;
          if (pos_step == HOME_POS) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = abort_seen_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Return home: skip the ramp entirely when already sitting at home.
    if (return_req) begin
      if (pos_q == HOME_POS) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        aborted_d = abort_seen_d;
      end else begin
        state_d    = MOVE_BACK;
        step_cnt_d = 20'd0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset snaps the servo straight home.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_q        <= HOME_POS;
      target_q     <= HOME_POS;
      step_cnt_q   <= 20'd0;
      hold_cnt_q   <= 25'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      target_q     <= target_d;
      step_cnt_q   <= step_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  assign pos     = pos_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: doc/pill_dispense_seq.md
# pill_dispense_seq

Dispense sequencer that sits directly upstream of the servo PWM stage and drives its 8-bit position input. It accepts one slot command over a valid/ready handshake, then runs a fixed sequence. The servo ramps from home to the slot angle at a limited slew rate, dwells there, ramps back to home, and reports completion. A one-cycle done pulse reports completion, and an abort input cuts the sequence short.

## Interface
Parameters:
- `STEP_CYCLES`, default 200000: clock cycles per 1-LSB position step (4 ms at 50 MHz, so a full 0–255 sweep takes about 1 s); ≥1, fits 20 bits.
- `HOLD_CYCLES`, default 25000000: dwell time at the slot position in cycles (0.5 s at 50 MHz); ≥1, fits 25 bits.
- `HOME_POS`, default 8'd0: rest position; value of `pos` at reset and when idle.
- `SLOT_PITCH`, default 8'd32: position increment per slot index.

Ports:
- `clk` in 1: system clock (50 MHz); the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_slot` in 3: slot index 0–7; sampled on accept.
- `cmd_ready` out 1: high only in IDLE with `rst` low.
- `abort` in 1: level input, sampled each cycle; forces the return to home.
- `pos` out 8: position to the servo stage; registered.
- `busy` out 1: high in any state other than IDLE; registered.
- `done` out 1: one-cycle pulse when the sequence has ended and `pos` = HOME_POS.
- `aborted` out 1: status of the last sequence; updated on the cycle `done` rises and held until the next `done`.

## Operation
- States: IDLE, MOVE_OUT, HOLD, MOVE_BACK.
- Target: `target = HOME_POS + cmd_slot*SLOT_PITCH`.
  - Computed in 12 bits, then saturated to 255.
  - Latched on accept; later changes on `cmd_slot` have no effect.
- Accept: a command is accepted on a clock edge where `cmd_valid & cmd_ready`. On that edge:
  - `step_cnt` and `hold_cnt` clear to 0.
  - The next state is MOVE_OUT, or HOLD if `target == pos`.
- MOVE_OUT and MOVE_BACK:
  - `step_cnt` increments every cycle.
  - When `step_cnt == STEP_CYCLES-1`: `step_cnt` goes to 0 and `pos` moves 1 LSB toward the goal (target for MOVE_OUT, HOME_POS for MOVE_BACK).
  - On the same edge that `pos` reaches the goal, the state advances.
    - MOVE_OUT advances to HOLD with `hold_cnt` = 0.
    - MOVE_BACK advances to IDLE and sets `done`.
  - `pos` never overshoots the goal and never wraps.
- HOLD:
  - `hold_cnt` increments every cycle.
  - When `hold_cnt == HOLD_CYCLES-1`, the state goes to MOVE_BACK with `step_cnt` = 0, or directly to IDLE with `done` if `pos == HOME_POS`.
- Abort:
  - When `abort` = 1 in MOVE_OUT or HOLD, the next edge goes to MOVE_BACK with `step_cnt` = 0, or to IDLE with `done` if `pos == HOME_POS`. The `aborted` flag sets with that `done`.
  - Abort takes priority over a step or hold expiry in the same cycle.
  - `abort` is ignored in IDLE and MOVE_BACK.
  - An abort seen in MOVE_OUT or HOLD is remembered; `aborted` is 1 at the following `done`, otherwise 0.
- Commands:
  - `cmd_valid` while busy is ignored: no queueing, no error.
  - The cycle `done` is high is already IDLE, so a new command can be accepted on that cycle.
- Reset: state IDLE, `pos` = HOME_POS (`pos` jumps immediately, even mid-sequence), counters 0, `busy` = 0, `done` = 0, `aborted` = 0, `cmd_ready` = 0 during reset. No `done` pulse is produced for an interrupted sequence.

## Timing
- `pos`, `busy`, `done` and `aborted` are registered; `cmd_ready` is decoded from the state register.
- Take the accept edge as edge E0. For a distance of D steps out, the timing is:
  - First `pos` change: E0+STEP_CYCLES.
  - `pos` reaches target at E0+D·STEP_CYCLES, entering HOLD.
  - MOVE_BACK entered at E0+D·STEP_CYCLES+HOLD_CYCLES.
  - `done` high for the single cycle after edge E0+2·D·STEP_CYCLES+HOLD_CYCLES.
- `busy` falls on the same edge that `done` rises.
- `pos` changes by at most 1 per STEP_CYCLES cycles at all times, except at reset.

## Test plan
Parameters for all scenarios unless noted: STEP_CYCLES=4, HOLD_CYCLES=10, SLOT_PITCH=32, HOME_POS=0.
- Slot 2 command accepted at E0:
  - `pos` = 1 after E4 and 64 after E256.
  - MOVE_BACK entered at E266; `pos` = 0 at E522.
  - `done` = 1 for one cycle after E522 with `aborted` = 0; `busy` high E1–E522.
- Slot 0 (zero distance): accept goes straight to HOLD; `done` after E10; `pos` stays 0 throughout.
- With HOME_POS=200, slot 7: target saturates to 255; `pos` climbs 200→255 in 55 steps (E220), HOLD, back to 200, `done`; `pos` never exceeds 255.
- Abort for one cycle when `pos` = 30 in MOVE_OUT:
  - MOVE_BACK entered on the next edge.
  - `pos` ramps 30→0 in 120 cycles.
  - `done` with `aborted` = 1.
  - A following normal slot 1 sequence ends with `aborted` = 0.
- `cmd_valid` held high with slot 5 during an active slot 1 sequence:
  - `cmd_ready` = 0 and the command is ignored until `done`.
  - On the `done` cycle the slot 5 command is accepted; the next target is 160.
- `rst` asserted mid-HOLD at `pos` = 96:
  - Next cycle `pos` = 0, `busy` = 0, and no `done` pulse.
  - After `rst` deasserts, `cmd_ready` = 1 and a new command is accepted normally.
